// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the CPU trace record streamer.
// A record is a header word, the PC, the instruction word, then the register file.
package cpu_trace_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      PC,
      INSTR,
      REGS,
      DONE
   } trace_state_e;

   localparam int FRAME_WORDS = 35;
   localparam logic [7:0] DEFAULT_HDR_MAGIC = 8'hA5;

   // Word offsets inside one record
   localparam int W_HDR   = 0;
   localparam int W_PC    = 1;
   localparam int W_INSTR = 2;
   localparam int W_REG0  = 3;

endpackage

// File: rtl/cpu_trace_streamer.sv
// Captures each retired instruction, stalls the core while the register file is
// dumped through a debug read port, and streams the record over valid/ready.
module cpu_trace_streamer
   import cpu_trace_pkg::*;
#(
   parameter int         NUM_REGS    = 32,
   parameter int         MAX_RECORDS = 153,
   parameter logic [7:0] HDR_MAGIC   = DEFAULT_HDR_MAGIC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        commit,
   input  logic [31:0] commit_pc,
   input  logic [31:0] commit_instr,
   output logic        cpu_stall,
   output logic [4:0]  rf_raddr,
   input  logic [31:0] rf_rdata,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [31:0] tx_data,
   output logic        tx_last,
   output logic        done,
   output logic        overflow
);

   localparam logic [4:0]  LAST_REG  = 5'(NUM_REGS - 1);
   localparam logic [15:0] MAX_REC16 = 16'(MAX_RECORDS);

   trace_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [4:0]   regIdx_q, regIdx_d;
   logic [15:0]  recIdx_q, recIdx_d;
   logic         overflow_q, overflow_d;

   logic busy;
   logic xfer;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         instr_q    <= '0;
         regIdx_q   <= '0;
         recIdx_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         regIdx_q   <= regIdx_d;
         recIdx_q   <= recIdx_d;
         overflow_q <= overflow_d;
      end
   end

   assign busy = (state_q == HDR) || (state_q == PC) ||
                 (state_q == INSTR) || (state_q == REGS);
   assign xfer = busy && tx_ready;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      regIdx_d   = regIdx_q;
      recIdx_d   = recIdx_q;
      overflow_d = overflow_q;

      // A commit arriving while a record is still in flight is lost; flag it
      if (busy && commit && enable) begin
         overflow_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (commit && enable) begin
               pc_d     = commit_pc;
               instr_d  = commit_instr;
               regIdx_d = '0;
               state_d  = HDR;
            end
         end
         HDR: begin
            if (xfer) state_d = PC;
         end
         PC: begin
            if (xfer) state_d = INSTR;
         end
         INSTR: begin
            if (xfer) state_d = REGS;
         end
         REGS: begin
            if (xfer) begin
               if (regIdx_q == LAST_REG) begin
                  regIdx_d = '0;
                  recIdx_d = recIdx_q + 16'd1;
                  state_d  = ((recIdx_q + 16'd1) == MAX_REC16) ? DONE : IDLE;
               end else begin
                  regIdx_d = regIdx_q + 5'd1;
               end
            end
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output word mux; REGS data comes straight from the stalled register file
   always_comb begin
      tx_data = '0;
      case (state_q)
         HDR:     tx_data = {HDR_MAGIC, 8'h00, recIdx_q};
         PC:      tx_data = pc_q;
         INSTR:   tx_data = instr_q;
         REGS:    tx_data = rf_rdata;
         default: tx_data = '0;
      endcase
   end

   assign tx_valid  = busy;
   assign cpu_stall = busy;
   assign tx_last   = (state_q == REGS) && (regIdx_q == LAST_REG);
   assign rf_raddr  = (state_q == REGS) ? regIdx_q : 5'd0;
   assign done      = (state_q == DONE);
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_cpu_trace_streamer.sv
// Scoreboard bench for cpu_trace_streamer: expected record words are queued when a
// commit is driven and compared against every valid word the streamer presents.
module tb_cpu_trace_streamer;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        commit;
   logic [31:0] commit_pc;
   logic [31:0] commit_instr;
   logic        cpu_stall;
   logic [4:0]  rf_raddr;
   logic [31:0] rf_rdata;
   logic        tx_valid;
   logic        tx_ready;
   logic [31:0] tx_data;
   logic        tx_last;
   logic        done;
   logic        overflow;

   logic [31:0] regs [32];
   logic [32:0] sb [$];
   int          assertCount;
   int          failCount;
   int          stallCycles;
   int          readyMode;

   cpu_trace_streamer #(.MAX_RECORDS(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .commit       (commit),
      .commit_pc    (commit_pc),
      .commit_instr (commit_instr),
      .cpu_stall    (cpu_stall),
      .rf_raddr     (rf_raddr),
      .rf_rdata     (rf_rdata),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .tx_data      (tx_data),
      .tx_last      (tx_last),
      .done         (done),
      .overflow     (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign rf_rdata = regs[rf_raddr];

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      assertCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic pushRecord(input logic [31:0] pc, input logic [31:0] instr, input logic [15:0] idx);
      sb.push_back({1'b0, 8'hA5, 8'h00, idx});
      sb.push_back({1'b0, pc});
      sb.push_back({1'b0, instr});
      for (int i = 0; i < 32; i++) begin
         sb.push_back({(i == 31), regs[i]});
      end
   endtask

   // Pulse commit for one cycle; optionally queue the record it should produce
   task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr,
                                input bit expectRecord, input logic [15:0] idx,
                                input bit expStall);
      @(posedge clk); #1;
      commit_pc    = pc;
      commit_instr = instr;
      commit       = 1'b1;
      if (expectRecord) pushRecord(pc, instr, idx);
      @(posedge clk); #1;
      commit = 1'b0;
      checkOutput("stallAfterCommit", 64'(cpu_stall), 64'(expStall));
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (cpu_stall && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (cpu_stall) checkOutput("idleTimeout", 64'(1), 64'(0));
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic doReset();
      @(posedge clk); #1;
      rst    = 1'b1;
      commit = 1'b0;
      @(posedge clk); #1;
      checkOutput("rstValid", 64'(tx_valid), 64'(0));
      checkOutput("rstStall", 64'(cpu_stall), 64'(0));
      checkOutput("rstDone", 64'(done), 64'(0));
      checkOutput("rstOverflow", 64'(overflow), 64'(0));
      checkOutput("rstData", 64'(tx_data), 64'(0));
      checkOutput("rstLast", 64'(tx_last), 64'(0));
      checkOutput("rstRaddr", 64'(rf_raddr), 64'(0));
      rst = 1'b0;
      sb.delete();
   endtask

   // Ready pattern driver: constant high, or repeating 1-0-0
   initial begin
      int phase;
      phase    = 0;
      tx_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (readyMode == 0) begin
            tx_ready = 1'b1;
         end else begin
            tx_ready = (phase == 0);
            phase    = (phase + 1) % 3;
         end
      end
   end

   // Monitor: every presented word must equal the scoreboard head, popped on transfer
   always @(negedge clk) begin
      if (!rst) begin
         if (cpu_stall) stallCycles++;
         if (tx_valid) begin
            if (sb.size() == 0) begin
               checkOutput("spuriousWord", 64'(tx_data), 64'(0));
            end else begin
               checkOutput("txData", 64'(tx_data), 64'(sb[0][31:0]));
               checkOutput("txLast", 64'(tx_last), 64'(sb[0][32]));
               if (tx_ready) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      int n;
      assertCount  = 0;
      failCount    = 0;
      stallCycles  = 0;
      readyMode    = 0;
      rst          = 1'b1;
      enable       = 1'b1;
      commit       = 1'b0;
      commit_pc    = '0;
      commit_instr = '0;
      for (int i = 0; i < 32; i++) regs[i] = 32'(i * 32'h11);

      doReset();

      // Record 0 with ready always high: 35 stalled cycles
      stallCycles = 0;
      applyStimulus(32'h0040_0000, 32'h2001_0005, 1'b1, 16'd0, 1'b1);
      waitIdle();
      checkOutput("stallCycles", 64'(stallCycles), 64'(35));
      checkOutput("sbEmpty0", 64'(sb.size()), 64'(0));
      checkOutput("doneAfter1", 64'(done), 64'(0));

      // Record 1 under backpressure; reaching MAX_RECORDS ends tracing
      readyMode = 1;
      applyStimulus(32'h0040_0004, 32'h2002_0007, 1'b1, 16'd1, 1'b1);
      waitIdle();
      readyMode = 0;
      checkOutput("sbEmpty1", 64'(sb.size()), 64'(0));
      checkOutput("doneAfter2", 64'(done), 64'(1));
      applyStimulus(32'h0040_0008, 32'h0000_0000, 1'b0, 16'd0, 1'b0);
      waitCycles(5);
      checkOutput("doneHold", 64'(done), 64'(1));
      checkOutput("doneNoValid", 64'(tx_valid), 64'(0));
      checkOutput("doneNoOverflow", 64'(overflow), 64'(0));

      // Commit while stalled sets sticky overflow without disturbing the record
      doReset();
      applyStimulus(32'h0040_0100, 32'h8C22_0010, 1'b1, 16'd0, 1'b1);
      waitCycles(5);
      applyStimulus(32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 16'd0, 1'b1);
      checkOutput("overflowSet", 64'(overflow), 64'(1));
      waitIdle();
      waitCycles(3);
      checkOutput("overflowSticky", 64'(overflow), 64'(1));
      checkOutput("sbEmpty2", 64'(sb.size()), 64'(0));
      checkOutput("noExtraRecord", 64'(tx_valid), 64'(0));

      // Reset in the middle of the register dump aborts the record
      applyStimulus(32'h0040_0200, 32'h0000_0020, 1'b1, 16'd1, 1'b1);
      n = 0;
      while (!(tx_valid && rf_raddr == 5'd10) && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("reachReg10", 64'(rf_raddr), 64'(10));
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("abortValid", 64'(tx_valid), 64'(0));
      checkOutput("abortStall", 64'(cpu_stall), 64'(0));
      checkOutput("abortOverflow", 64'(overflow), 64'(0));
      rst = 1'b0;
      sb.delete();
      applyStimulus(32'h0040_0300, 32'h0800_0000, 1'b1, 16'd0, 1'b1);
      waitIdle();
      checkOutput("sbEmpty3", 64'(sb.size()), 64'(0));

      // Disabled commits are ignored; enable dropping mid-record does not abort
      doReset();
      enable = 1'b0;
      applyStimulus(32'h0040_0400, 32'h1111_1111, 1'b0, 16'd0, 1'b0);
      waitCycles(3);
      checkOutput("disabledValid", 64'(tx_valid), 64'(0));
      enable = 1'b1;
      applyStimulus(32'h0040_0404, 32'h2222_2222, 1'b1, 16'd0, 1'b1);
      waitCycles(5);
      enable = 1'b0;
      waitIdle();
      checkOutput("sbEmpty4", 64'(sb.size()), 64'(0));
      checkOutput("doneAfterOne", 64'(done), 64'(0));
      enable = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
